// File: rtl/slowram_arb.sv
// slowram_arb: arbitrates direct CPU E0/E1 accesses and queued shadow writes onto one
// slow-RAM operation per 1 MHz slot; queued shadow writes always drain before CPU access.
module slowram_arb #(
    parameter int SLOT_DIV   = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [16:0]                 cpu_addr,
    input  logic [7:0]                  cpu_din,
    output logic [7:0]                  cpu_dout,
    output logic                        cpu_wait,
    input  logic                        shd_req,
    input  logic [16:0]                 shd_addr,
    input  logic [7:0]                  shd_data,
    output logic                        ram_ce,
    output logic                        ram_we,
    output logic [16:0]                 ram_addr,
    output logic [7:0]                  ram_din,
    input  logic [7:0]                  ram_dout,
    output logic                        slot,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CW = SLOT_DIV > 1 ? $clog2(SLOT_DIV) : 1;
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, WAIT_SLOT, ACCESS, DATA, DRAIN} state_t;

    state_t        state, ret;
    logic [CW-1:0] cnt;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [16:0]   fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic          lat_we;
    logic [16:0]   lat_addr;
    logic [7:0]    lat_din, dout_r;
    logic          empty, pop, push;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign slot      = cnt == CW'(SLOT_DIV - 1);
    assign empty     = fifo_count == '0;
    assign fifo_full = fifo_count == NW'(FIFO_DEPTH);
    // The head is popped on the slot cycle itself so a full FIFO can accept a write that same cycle.
    assign pop       = slot && !empty && (state == IDLE || state == WAIT_SLOT);
    assign push      = shd_req && (!fifo_full || pop);
    assign cpu_wait  = (cpu_req && state == IDLE) || state == WAIT_SLOT || state == ACCESS ||
                       (state == DRAIN && ret == WAIT_SLOT) || (shd_req && fifo_full && !pop);
    // Read data is forwarded straight from the RAM in DATA so the CPU can release that cycle.
    assign cpu_dout  = (state == DATA && !lat_we) ? ram_dout : dout_r;

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= shd_addr;
            fifo_data[wr_ptr] <= shd_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            ret        <= IDLE;
            cnt        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            dout_r     <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_din    <= '0;
        end else begin
            cnt        <= slot ? '0 : cnt + 1'b1;
            fifo_count <= fifo_count + NW'(push) - NW'(pop);
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case (state)
                IDLE, WAIT_SLOT: begin
                    if (pop) begin
                        ram_ce   <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_addr <= fifo_addr[rd_ptr];
                        ram_din  <= fifo_data[rd_ptr];
                        ret      <= state;
                        state    <= DRAIN;
                    end else if (state == WAIT_SLOT && slot) begin
                        ram_ce   <= 1'b1;
                        ram_we   <= lat_we;
                        ram_addr <= lat_addr;
                        ram_din  <= lat_din;
                        state    <= ACCESS;
                    end else if (state == IDLE && cpu_req) begin
                        lat_we   <= cpu_we;
                        lat_addr <= cpu_addr;
                        lat_din  <= cpu_din;
                        state    <= WAIT_SLOT;
                    end
                end
                ACCESS: state <= DATA;
                DATA: begin
                    if (!lat_we) dout_r <= ram_dout;
                    state <= IDLE;
                end
                DRAIN: state <= ret;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slowram_arb.sv
// tb_slowram_arb: directed timing scenarios plus randomized CPU/shadow traffic, all
// checked every cycle against a transaction-level model of the arbiter and slow RAM.
module tb_slowram_arb;
    localparam int SD = 14;
    localparam int D  = 4;

    logic        clk_sys = 0, reset = 1;
    logic        cpu_req = 0, cpu_we = 0, shd_req = 0;
    logic [16:0] cpu_addr = 0, shd_addr = 0;
    logic [7:0]  cpu_din = 0, shd_data = 0, ram_dout = 0;
    logic [7:0]  cpu_dout, ram_din;
    logic        cpu_wait, ram_ce, ram_we, slot, fifo_full;
    logic [16:0] ram_addr;
    logic [2:0]  fifo_count;

    always #5 clk_sys = ~clk_sys;

    slowram_arb #(.SLOT_DIV(SD), .FIFO_DEPTH(D)) dut (
        .clk_sys(clk_sys), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .shd_req(shd_req), .shd_addr(shd_addr), .shd_data(shd_data),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .slot(slot), .fifo_full(fifo_full), .fifo_count(fifo_count)
    );

    logic [7:0] ram  [0:131071];
    logic [7:0] mmem [0:131071];

    always @(posedge clk_sys) begin
        if (ram_ce) begin
            if (ram_we) ram[ram_addr] <= ram_din;
            else ram_dout <= ram[ram_addr];
        end
    end

    int errors = 0, checks = 0, cyc = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, act, exp);
        end
    endtask

    // Model: a shadow-write queue, one pending CPU op, and the phase of the current cycle
    // (0 = no RAM activity, 1 = drain write, 2 = CPU RAM access, 3 = CPU data return).
    typedef struct packed {logic [16:0] a; logic [7:0] d;} wr_t;
    wr_t         q[$];
    wr_t         h;
    bit          m_valid = 0, pend = 0, p_we = 0, e_ce = 0, e_we = 0, m_push = 0, m_cdone = 0;
    bit          e_slot, idle, pop, full, e_wait;
    int          phase = 0, nph = 0, m_cnt = 0;
    logic [16:0] p_a = 0, e_addr = 0;
    logic [7:0]  p_d = 0, e_din = 0, dout_r = 0, rd_val = 0, e_dout;

    always @(negedge clk_sys) begin
        e_slot = m_cnt == SD - 1;
        idle   = !pend && phase == 0;
        full   = q.size() == D;
        pop    = e_slot && q.size() != 0 && phase == 0;
        e_wait = (cpu_req && idle) || pend || phase == 2 || (shd_req && full && !pop);
        e_dout = (phase == 3 && !p_we) ? rd_val : dout_r;
        if (m_valid) begin
            chk("slot", slot, e_slot);
            chk("cpu_wait", cpu_wait, e_wait);
            chk("cpu_dout", cpu_dout, e_dout);
            chk("ram_ce", ram_ce, e_ce);
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_din", ram_din, e_din);
            chk("fifo_count", fifo_count, q.size());
            chk("fifo_full", fifo_full, full);
        end
        m_push  = shd_req && (!full || pop) && !reset;
        m_cdone = cpu_req && !e_wait;
        if (m_valid && e_ce) begin
            if (e_we) mmem[e_addr] = e_din;
            else rd_val = mmem[e_addr];
        end
        if (reset) begin
            q.delete();
            pend = 0; p_we = 0; p_a = 0; p_d = 0; phase = 0; m_cnt = 0;
            e_ce = 0; e_we = 0; e_addr = 0; e_din = 0; dout_r = 0;
            m_valid = 1;
        end else begin
            if (phase == 3 && !p_we) dout_r = rd_val;
            nph  = 0;
            e_ce = 0;
            e_we = 0;
            if (pop) begin
                h = q.pop_front();
                e_ce = 1; e_we = 1; e_addr = h.a; e_din = h.d; nph = 1;
            end else if (pend && phase == 0 && e_slot) begin
                e_ce = 1; e_we = p_we; e_addr = p_a; e_din = p_d; pend = 0; nph = 2;
            end else if (phase == 2) begin
                nph = 3;
            end else if (idle && cpu_req) begin
                pend = 1; p_we = cpu_we; p_a = cpu_addr; p_d = cpu_din;
            end
            if (m_push) q.push_back({shd_addr, shd_data});
            m_cnt = e_slot ? 0 : m_cnt + 1;
            phase = nph;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
        cyc++;
        if (cpu_req && m_cdone) cpu_req = 0;
        if (shd_req && m_push) shd_req = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cpu_req = 0;
        shd_req = 0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset = 0;
        cyc = 0;
    endtask

    task automatic cpu_op(input logic we, input logic [16:0] a, input logic [7:0] d);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_din = d;
    endtask

    task automatic shd_op(input logic [16:0] a, input logic [7:0] d);
        shd_req = 1; shd_addr = a; shd_data = d;
    endtask

    initial begin
        int n, pulses;
        bit seen;
        for (int i = 0; i < 131072; i++) begin
            ram[i]  = 8'(i * 37 + 11);
            mmem[i] = ram[i];
        end
        ram[17'h12000]  = 8'h5A;
        mmem[17'h12000] = 8'h5A;

        // Idle: slot timing, no RAM activity.
        do_reset();
        seen = 0;
        for (int k = 0; k < 43; k++) begin
            @(negedge clk_sys);
            if (cyc == 12 || cyc == 13 || cyc == 27 || cyc == 41)
                chk("idle_slot", slot, cyc != 12);
            if (cyc == 0) chk("reset_wait", cpu_wait, 0);
            seen |= ram_ce;
            tick();
        end
        chk("idle_no_ce", seen, 0);

        // CPU read of 0x1_2000.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (cyc == 2) cpu_op(0, 17'h12000, 8'h00);
            @(negedge clk_sys);
            if (cyc == 2) chk("rd_wait_start", cpu_wait, 1);
            if (cyc == 13) chk("rd_ce_early", ram_ce, 0);
            if (cyc == 14) chk("rd_ce", ram_ce, 1);
            if (cyc == 14) chk("rd_wait_acc", cpu_wait, 1);
            if (cyc == 15) chk("rd_wait_end", cpu_wait, 0);
            if (cyc == 15) chk("rd_dout", cpu_dout, 8'h5A);
            tick();
        end

        // Five back-to-back shadow writes.
        do_reset();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (cyc >= 1 && !shd_req && n < 5) begin
                shd_op(17'h00100 + 17'(n), 8'(8'hA0 + n));
                n++;
            end
            @(negedge clk_sys);
            if (cyc == 4) chk("bb_full_early", fifo_full, 0);
            if (cyc == 5) chk("bb_full", fifo_full, 1);
            if (cyc == 5 || cyc == 12) chk("bb_wait", cpu_wait, 1);
            if (cyc == 13) chk("bb_wait_pop", cpu_wait, 0);
            if (cyc == 14) chk("bb_count", fifo_count, 4);
            tick();
        end

        // Shadow write then CPU read of the same address.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            if (cyc == 1) shd_op(17'h00400, 8'hC1);
            if (cyc == 2) cpu_op(0, 17'h00400, 8'h00);
            @(negedge clk_sys);
            if (cyc == 14) chk("hz_drain_ce", {ram_ce, ram_we, 7'h0, ram_addr}, {2'b11, 7'h0, 17'h00400});
            if (cyc == 27) chk("hz_ce_early", ram_ce, 0);
            if (cyc == 28) chk("hz_cpu_ce", {ram_ce, ram_we}, 2'b10);
            if (cyc == 29) chk("hz_dout", {cpu_wait, cpu_dout}, {1'b0, 8'hC1});
            tick();
        end

        // Reset asserted during a CPU write ACCESS with shadow writes queued.
        do_reset();
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (cyc == 2) cpu_op(1, 17'h10100, 8'h77);
            if (cyc == 13) shd_op(17'h00200, 8'h11);
            if (cyc == 14) begin
                shd_op(17'h00201, 8'h22);
                reset = 1;
            end
            if (cyc == 15) begin
                reset = 0;
                cpu_req = 0;
                shd_req = 0;
            end
            @(negedge clk_sys);
            if (cyc == 14) chk("rs_in_access", ram_ce, 1);
            if (cyc == 15) begin
                chk("rs_ram", {ram_ce, ram_we, ram_addr, ram_din}, 0);
                chk("rs_fifo", {fifo_full, fifo_count}, 0);
                chk("rs_out", {cpu_wait, cpu_dout, slot}, 0);
            end
            if (cyc > 15) seen |= ram_ce;
            tick();
        end
        chk("rs_no_write", seen, 0);

        // CPU write 0x0_C000 = 0x33.
        do_reset();
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (cyc == 2) cpu_op(1, 17'h0C000, 8'h33);
            @(negedge clk_sys);
            if (ram_ce) pulses++;
            if (cyc == 14) chk("wr_ram", {ram_we, ram_addr, ram_din}, {1'b1, 17'h0C000, 8'h33});
            if (cyc == 15) chk("wr_dout", {cpu_wait, cpu_dout}, 0);
            tick();
        end
        chk("wr_pulses", pulses, 1);

        // Randomized traffic on a small address set to provoke read-after-shadow-write hazards.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            tick();
            if ($urandom_range(0, 999) == 0) begin
                reset = 1;
                cpu_req = 0;
                shd_req = 0;
            end else begin
                reset = 0;
                if (!cpu_req && $urandom_range(0, 3) == 0)
                    cpu_op(1'($urandom_range(0, 1)),
                           {1'($urandom_range(0, 1)), 12'h000, 4'($urandom_range(0, 15))},
                           8'($urandom));
                if (!shd_req && $urandom_range(0, ((k / 500) % 2) ? 2 : 20) == 0)
                    shd_op({1'($urandom_range(0, 1)), 12'h000, 4'($urandom_range(0, 15))},
                           8'($urandom));
            end
        end
        @(negedge clk_sys);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
